audio_nios_pll_reset_ctrl: RTL and testbench

Reset/lock sequencer for the audio subsystem PLL, which produces the 100 MHz, 100 MHz/7.5 ns and 10 MHz outputs. It runs on the PLL reference clock and performs four jobs:
- pulses the PLL reset;
- synchronises and qualifies the PLL `locked` output;
- releases the system reset only after lock has been stable for a programmed interval;
- on loss of lock, re-sequences the PLL with bounded retries and a sticky fault.

It sits between the board reset and the clock-domain reset synchronisers of the Nios/audio system.

---
 rtl/audio_nios_pll_reset_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_audio_nios_pll_reset_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_nios_pll_reset_ctrl.sv
// Purpose: reset/lock sequencer for the audio PLL: pulses pll_rst, qualifies lock, gates the system reset.
// Latency: lock rise -> sys_reset_n rise = 2 + LOCK_STABLE_CYCLES cycles; lock fall in RUN -> outputs = 3 cycles.
// Backpressure: none; every input is sampled each refclk cycle and all outputs are registered.
module audio_nios_pll_reset_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16,
  localparam int unsigned RC_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic            refclk,
  input  logic            rst_n,
  input  logic            sw_reset_req,
  input  logic            pll_locked,
  output logic            pll_rst,
  output logic            sys_reset_n,
  output logic            lock_ok,
  output logic            fault,
  output logic            lost_lock,
  output logic [RC_W-1:0] retry_cnt,
  output logic [7:0]      loss_cnt
);

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_WAIT    = 3'd1,
    ST_QUALIFY = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [RC_W-1:0]  RETRY_MAX  = RC_W'(MAX_RETRIES);
  localparam logic [RC_W-1:0]  RETRY_ONE  = RC_W'(1);

  // lock synchroniser
  logic lock_meta_q;
  logic lock_s_q;

  // sequencer state and counters
  state_e           state_q, state_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [RC_W-1:0]  retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;

  // registered outputs
  logic pll_rst_q, pll_rst_d;
  logic sys_rst_n_q, sys_rst_n_d;
  logic fault_q, fault_d;
  logic lost_q, lost_d;

  // helper terms
  logic [RC_W-1:0] retry_inc;
  logic            qual_done;
  logic            tmo_hit;

  // Two-flop synchroniser for the asynchronous PLL locked output.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  // stab_cnt holds the number of lock_s cycles already seen; it is always zero
  // in WAIT, so the WAIT cycle that sees lock counts as the first stable cycle
  // and the same compare works from WAIT (single-cycle qualify) and QUALIFY.
  assign qual_done = lock_s_q && (stab_cnt_q == STAB_LAST);
  assign tmo_hit   = (tmo_cnt_q == TMO_LAST);
  assign retry_inc = retry_q + RETRY_ONE;

  // Next-state, counter and output decode, prioritised sw request > qualify > timeout.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    stab_cnt_d  = stab_cnt_q;
    retry_d     = retry_q;
    loss_d      = loss_q;
    lost_d      = 1'b0;

    if (sw_reset_req) begin
      state_d     = ST_ASSERT;
      pulse_cnt_d = '0;
      tmo_cnt_d   = '0;
      stab_cnt_d  = '0;
      retry_d     = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (pulse_cnt_q == PULSE_LAST) begin
            state_d     = ST_WAIT;
            pulse_cnt_d = '0;
            tmo_cnt_d   = '0;
            stab_cnt_d  = '0;
          end else begin
            pulse_cnt_d = pulse_cnt_q + CNT_ONE;
          end
        end

        ST_WAIT, ST_QUALIFY: begin
          if (qual_done) begin
            state_d    = ST_RUN;
            stab_cnt_d = '0;
          end else if (tmo_hit) begin
            retry_d     = retry_inc;
            state_d     = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_ASSERT;
            pulse_cnt_d = '0;
            tmo_cnt_d   = '0;
            stab_cnt_d  = '0;
          end else begin
            // timeout keeps running across lock glitches within one attempt
            tmo_cnt_d = tmo_cnt_q + CNT_ONE;
            if (lock_s_q) begin
              state_d    = ST_QUALIFY;
              stab_cnt_d = stab_cnt_q + CNT_ONE;
            end else begin
              state_d    = ST_WAIT;
              stab_cnt_d = '0;
            end
          end
        end

        ST_RUN: begin
          if (!lock_s_q) begin
            state_d     = ST_ASSERT;
            lost_d      = 1'b1;
            loss_d      = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
            retry_d     = '0;
            pulse_cnt_d = '0;
            tmo_cnt_d   = '0;
            stab_cnt_d  = '0;
          end
        end

        ST_FAULT: begin
          state_d = ST_FAULT;
        end

        default: begin
          // unreachable encodings fall back to a fresh PLL reset pulse
          state_d     = ST_ASSERT;
          pulse_cnt_d = '0;
          tmo_cnt_d   = '0;
          stab_cnt_d  = '0;
        end
      endcase
    end

    // outputs are decoded from the next state so they switch with the state
    pll_rst_d   = (state_d == ST_ASSERT);
    sys_rst_n_d = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ASSERT;
      pulse_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      stab_cnt_q  <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      fault_q     <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      fault_q     <= fault_d;
      lost_q      <= lost_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset_n = sys_rst_n_q;
  assign lock_ok     = sys_rst_n_q;
  assign fault       = fault_q;
  assign lost_lock   = lost_q;
  assign retry_cnt   = retry_q;
  assign loss_cnt    = loss_q;

  // The PLL is never held in reset while the system is released or faulted.
  a_rst_excl: assert property (@(posedge refclk) disable iff (!rst_n)
    !(pll_rst_q && sys_rst_n_q));
  a_fault_quiet: assert property (@(posedge refclk) disable iff (!rst_n)
    !(fault_q && (pll_rst_q || sys_rst_n_q)));

endmodule

// File: tb/tb_audio_nios_pll_reset_ctrl.sv
// Bench for audio_nios_pll_reset_ctrl: scripted stimulus pushes expected output
// transitions (kind, value, cycle) to a queue; a negedge monitor pops and compares.
module tb_audio_nios_pll_reset_ctrl;

  localparam int P_PULSE = 4;
  localparam int P_TMO   = 20;
  localparam int P_STAB  = 8;
  localparam int P_MAXR  = 2;
  localparam int RCW     = $clog2(P_MAXR + 1);

  localparam int K_PLLRST = 0;
  localparam int K_SYSRST = 1;
  localparam int K_LOCKOK = 2;
  localparam int K_FAULT  = 3;
  localparam int K_LOST   = 4;
  localparam int K_RETRY  = 5;
  localparam int K_LOSS   = 6;

  logic           refclk = 1'b0;
  logic           rst_n = 1'b1;
  logic           sw_reset_req = 1'b0;
  logic           pll_locked = 1'b0;
  logic           pll_rst;
  logic           sys_reset_n;
  logic           lock_ok;
  logic           fault;
  logic           lost_lock;
  logic [RCW-1:0] retry_cnt;
  logic [7:0]     loss_cnt;

  audio_nios_pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (P_PULSE),
    .LOCK_TIMEOUT_CYCLES(P_TMO),
    .LOCK_STABLE_CYCLES (P_STAB),
    .MAX_RETRIES        (P_MAXR),
    .CNT_W              (16)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .sw_reset_req(sw_reset_req),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .lock_ok     (lock_ok),
    .fault       (fault),
    .lost_lock   (lost_lock),
    .retry_cnt   (retry_cnt),
    .loss_cnt    (loss_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;

  always @(posedge refclk) cyc = cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      K_PLLRST: return "pll_rst";
      K_SYSRST: return "sys_reset_n";
      K_LOCKOK: return "lock_ok";
      K_FAULT:  return "fault";
      K_LOST:   return "lost_lock";
      K_RETRY:  return "retry_cnt";
      default:  return "loss_cnt";
    endcase
  endfunction

  task automatic expect_ev(input int k, input int v, input int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Match an observed transition against the oldest expectation of that kind.
  task automatic got_ev(input int k, input int v, input int c);
    int idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i].kind == k) idx = i;
    chk({kname(k), "_transition_expected"}, (idx >= 0) ? 1 : 0, 1);
    if (idx >= 0) begin
      chk({kname(k), "_value"}, v, exp_q[idx].val);
      chk({kname(k), "_cycle"}, c, exp_q[idx].cyc);
      exp_q.delete(idx);
    end
  endtask

  logic           p_pll_rst, p_sys, p_lok, p_fault, p_lost;
  logic [RCW-1:0] p_retry;
  logic [7:0]     p_loss;

  always @(negedge refclk) begin
    if (mon_en) begin
      if (pll_rst !== p_pll_rst)   got_ev(K_PLLRST, int'(pll_rst), cyc);
      if (sys_reset_n !== p_sys)   got_ev(K_SYSRST, int'(sys_reset_n), cyc);
      if (lock_ok !== p_lok)       got_ev(K_LOCKOK, int'(lock_ok), cyc);
      if (fault !== p_fault)       got_ev(K_FAULT, int'(fault), cyc);
      if (lost_lock !== p_lost)    got_ev(K_LOST, int'(lost_lock), cyc);
      if (retry_cnt !== p_retry)   got_ev(K_RETRY, int'(retry_cnt), cyc);
      if (loss_cnt !== p_loss)     got_ev(K_LOSS, int'(loss_cnt), cyc);
    end
    p_pll_rst = pll_rst;
    p_sys     = sys_reset_n;
    p_lok     = lock_ok;
    p_fault   = fault;
    p_lost    = lost_lock;
    p_retry   = retry_cnt;
    p_loss    = loss_cnt;
  end

  // Advance to 1 time unit after rising edge number c.
  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, int'(pll_rst), 1);
    chk({tag, "_sys_reset_n"}, int'(sys_reset_n), 0);
    chk({tag, "_lock_ok"}, int'(lock_ok), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_lost_lock"}, int'(lost_lock), 0);
    chk({tag, "_retry_cnt"}, int'(retry_cnt), 0);
    chk({tag, "_loss_cnt"}, int'(loss_cnt), 0);
  endtask

  // Called 1 unit after an edge: drops rst_n mid-cycle and checks outputs before any edge.
  task automatic async_reset(input string tag);
    chk({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    #1;
    rst_n      = 1'b0;
    mon_en     = 1'b0;
    pll_locked = 1'b0;
    #1;
    check_reset_vals(tag);
  endtask

  task automatic release_rst(output int r);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    r      = cyc;
  endtask

  // Lock drop in RUN at cycle d: everything reacts on edge d+3, then a fresh pulse.
  task automatic expect_loss(input int d, input int loss_val);
    expect_ev(K_SYSRST, 0, d + 3);
    expect_ev(K_LOCKOK, 0, d + 3);
    expect_ev(K_PLLRST, 1, d + 3);
    expect_ev(K_LOST,   1, d + 3);
    expect_ev(K_LOSS,   loss_val, d + 3);
    expect_ev(K_LOST,   0, d + 4);
    expect_ev(K_PLLRST, 0, d + 3 + P_PULSE);
  endtask

  task automatic expect_run(input int c);
    expect_ev(K_SYSRST, 1, c);
    expect_ev(K_LOCKOK, 1, c);
  endtask

  initial begin
    int r, l, d, f, g;
    #1 rst_n = 1'b0;

    // reset state
    to_cyc(3);
    check_reset_vals("reset");

    // power-up lock, lock raised 3 cycles after pll_rst falls
    to_cyc(4);
    release_rst(r);
    expect_ev(K_PLLRST, 0, r + P_PULSE);
    to_cyc(r + P_PULSE + 3);
    pll_locked = 1'b1;
    l = cyc;
    expect_run(l + 2 + P_STAB);
    to_cyc(l + 2 + P_STAB + 2);
    chk("powerup_retry_cnt", int'(retry_cnt), 0);

    // loss in RUN, then relock
    d = l + 15;
    to_cyc(d);
    pll_locked = 1'b0;
    expect_loss(d, 1);
    to_cyc(d + 3 + P_PULSE + 2);
    pll_locked = 1'b1;
    expect_run(cyc + 2 + P_STAB);
    to_cyc(d + 25);
    async_reset("rst_in_run");

    // lock glitch during QUALIFY
    to_cyc(cyc + 3);
    release_rst(r);
    expect_ev(K_PLLRST, 0, r + P_PULSE);
    to_cyc(r + 4);
    pll_locked = 1'b1;
    to_cyc(r + 9);
    pll_locked = 1'b0;
    to_cyc(r + 10);
    pll_locked = 1'b1;
    expect_run(r + 10 + 2 + P_STAB);
    to_cyc(r + 23);
    async_reset("rst_after_glitch");

    // reset while in QUALIFY
    to_cyc(cyc + 2);
    release_rst(r);
    expect_ev(K_PLLRST, 0, r + P_PULSE);
    to_cyc(r + 6);
    pll_locked = 1'b1;
    to_cyc(r + 11);
    async_reset("rst_in_qualify");

    // no lock: two timed-out attempts then FAULT
    to_cyc(cyc + 2);
    release_rst(r);
    expect_ev(K_PLLRST, 0, r + P_PULSE);
    expect_ev(K_RETRY,  1, r + P_PULSE + P_TMO);
    expect_ev(K_PLLRST, 1, r + P_PULSE + P_TMO);
    expect_ev(K_PLLRST, 0, r + 2 * P_PULSE + P_TMO);
    expect_ev(K_RETRY,  2, r + 2 * (P_PULSE + P_TMO));
    expect_ev(K_FAULT,  1, r + 2 * (P_PULSE + P_TMO));
    to_cyc(r + 52);
    chk("fault_held", int'(fault), 1);
    chk("fault_pll_rst", int'(pll_rst), 0);
    chk("fault_sys_reset_n", int'(sys_reset_n), 0);
    chk("fault_lock_ok", int'(lock_ok), 0);

    // software restart out of FAULT
    sw_reset_req = 1'b1;
    f = cyc;
    expect_ev(K_FAULT,  0, f + 1);
    expect_ev(K_RETRY,  0, f + 1);
    expect_ev(K_PLLRST, 1, f + 1);
    expect_ev(K_PLLRST, 0, f + 1 + P_PULSE);
    to_cyc(f + 1);
    sw_reset_req = 1'b0;
    to_cyc(f + 3);
    chk("sw_retry_cnt", int'(retry_cnt), 0);
    chk("sw_fault", int'(fault), 0);
    chk("sw_pll_rst", int'(pll_rst), 1);

    // qualification completes on the same edge as the timeout
    to_cyc(f + 1 + P_PULSE + P_TMO - 2 - P_STAB);
    pll_locked = 1'b1;
    expect_run(f + 1 + P_PULSE + P_TMO);
    to_cyc(f + 28);
    chk("simul_qual_retry_cnt", int'(retry_cnt), 0);

    // lock loss, one timeout, then sw request on the edge that would fault
    g = f + 30;
    to_cyc(g);
    pll_locked = 1'b0;
    expect_loss(g, 1);
    expect_ev(K_RETRY,  1, g + 3 + P_PULSE + P_TMO);
    expect_ev(K_PLLRST, 1, g + 3 + P_PULSE + P_TMO);
    expect_ev(K_PLLRST, 0, g + 3 + 2 * P_PULSE + P_TMO);
    to_cyc(g + 3 + 2 * (P_PULSE + P_TMO) - 1);
    sw_reset_req = 1'b1;
    expect_ev(K_PLLRST, 1, cyc + 1);
    expect_ev(K_RETRY,  0, cyc + 1);
    expect_ev(K_PLLRST, 0, cyc + 1 + P_PULSE);
    to_cyc(cyc + 1);
    sw_reset_req = 1'b0;
    to_cyc(cyc + 2);
    chk("simul_sw_retry_cnt", int'(retry_cnt), 0);
    chk("simul_sw_fault", int'(fault), 0);

    to_cyc(cyc + 8);
    chk("final_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
